// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
// The sequencer side holds the master modport; the adder holds the slave.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// one bit per clock, with registered sum/carry-out/signed-overflow results.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             s_bit;
    logic             c_bit;

    assign s_bit = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign c_bit = (op_a_q[0] & op_b_q[0]) | (op_b_q[0] & carry_q) | (carry_q & op_a_q[0]);

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // op_a doubles as the result shift register: sum bits enter at
                // the MSB as operand bits leave at the LSB.
                op_a_d  = {s_bit, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s_bit, op_a_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    ovf_d   = c_bit ^ carry_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 cases, handshake and reset,
// exhaustive WIDTH=4 sweep, random WIDTH=2 and WIDTH=32 runs.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    logic [65:0] q8[$];
    logic [65:0] q4[$];
    logic [65:0] q2[$];
    logic [65:0] q32[$];

    serial_adder_if #(.WIDTH(8))  i8();
    serial_adder_if #(.WIDTH(4))  i4();
    serial_adder_if #(.WIDTH(2))  i2();
    serial_adder_if #(.WIDTH(32)) i32();

    serial_adder #(.WIDTH(8))  d8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_adder #(.WIDTH(4))  d4  (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    serial_adder #(.WIDTH(2))  d2  (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    serial_adder #(.WIDTH(32)) d32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add/subtract, overflow from operand signs.
    function automatic logic [65:0] model(input int w, input logic sub, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
        logic [64:0] mask;
        logic [63:0] am, bb, s;
        logic [64:0] full;
        logic        co, ov;
        mask = (65'd1 << w) - 65'd1;
        am   = a & mask[63:0];
        bb   = (sub ? ~b : b) & mask[63:0];
        full = {1'b0, am} + {1'b0, bb} + {64'd0, cin ^ sub};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    logic p8, p4, p2, p32;
    always @(negedge clk) begin
        if (p8)  chk("done8_pulse",  {65'd0, i8.done},  66'd0);
        if (p4)  chk("done4_pulse",  {65'd0, i4.done},  66'd0);
        if (p2)  chk("done2_pulse",  {65'd0, i2.done},  66'd0);
        if (p32) chk("done32_pulse", {65'd0, i32.done}, 66'd0);
        p8 = i8.done; p4 = i4.done; p2 = i2.done; p32 = i32.done;
        if (i8.done) begin
            chk("sb8_pending", {65'd0, q8.size() != 0}, 66'd1);
            if (q8.size() != 0) chk("res8", {i8.ovf, i8.cout, 56'd0, i8.sum}, q8.pop_front());
        end
        if (i4.done) begin
            chk("sb4_pending", {65'd0, q4.size() != 0}, 66'd1);
            if (q4.size() != 0) chk("res4", {i4.ovf, i4.cout, 60'd0, i4.sum}, q4.pop_front());
        end
        if (i2.done) begin
            chk("sb2_pending", {65'd0, q2.size() != 0}, 66'd1);
            if (q2.size() != 0) chk("res2", {i2.ovf, i2.cout, 62'd0, i2.sum}, q2.pop_front());
        end
        if (i32.done) begin
            chk("sb32_pending", {65'd0, q32.size() != 0}, 66'd1);
            if (q32.size() != 0) chk("res32", {i32.ovf, i32.cout, 32'd0, i32.sum}, q32.pop_front());
        end
    end

    // Call at posedge+1 with the 8-bit DUT idle at the next edge; returns
    // start-to-done latency and busy cycle count. Start is poked during RUN and DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo,
                       output int lat, output int nb);
        i8.a = a; i8.b = b; i8.cin = cin; i8.sub = sub; i8.start = 1'b1;
        q8.push_back({eo, ec, 56'd0, es});
        lat = -1;
        nb  = 0;
        @(posedge clk); #1;
        for (int j = 1; j <= 9; j++) begin
            i8.start = (j == 3 || j == 9);
            i8.a = 8'($urandom); i8.b = 8'($urandom);
            i8.cin = 1'($urandom); i8.sub = 1'($urandom);
            @(negedge clk);
            if (i8.busy) nb++;
            if (i8.done && lat < 0) lat = j - 1;
            @(posedge clk); #1;
        end
        i8.start = 1'b0;
    endtask

    initial begin
        int lat, nb;
        logic [7:0] ha, hb;
        logic hc, hs;
        n_total = 0; n_bad = 0;
        p8 = 0; p4 = 0; p2 = 0; p32 = 0;
        {i8.start, i8.a, i8.b, i8.cin, i8.sub}     = '0;
        {i4.start, i4.a, i4.b, i4.cin, i4.sub}     = '0;
        {i2.start, i2.a, i2.b, i2.cin, i2.sub}     = '0;
        {i32.start, i32.a, i32.b, i32.cin, i32.sub} = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {58'd0, i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}, 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, lat, nb);
        chk("lat_5a3c",  66'(lat), 66'd8);
        chk("busy_5a3c", 66'(nb),  66'd8);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, lat, nb);
        op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, lat, nb);
        op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, lat, nb);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, lat, nb);
        op8(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, lat, nb);
        chk("lat_sub", 66'(lat), 66'd8);

        // start held high: only every tenth edge may be accepted
        for (int i = 0; i < 50; i++) begin
            ha = 8'($urandom); hb = 8'($urandom); hc = 1'($urandom); hs = 1'($urandom);
            i8.a = ha; i8.b = hb; i8.cin = hc; i8.sub = hs; i8.start = 1'b1;
            if (i % 10 == 0) q8.push_back(model(8, hs, {56'd0, ha}, {56'd0, hb}, hc));
            @(posedge clk); #1;
        end
        i8.start = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("hs_drain", 66'(q8.size()), 66'd0);

        // reset four cycles into an operation
        i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0; i8.sub = 1'b0; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_outs", {58'd0, i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}, 66'd0);
        repeat (12) @(posedge clk); #1;
        op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, lat, nb);
        chk("lat_after_rst", 66'(lat), 66'd8);

        fork
            begin : w4
                for (int s = 0; s < 2; s++)
                    for (int a = 0; a < 16; a++)
                        for (int b = 0; b < 16; b++)
                            for (int c = 0; c < 2; c++) begin
                                i4.a = a[3:0]; i4.b = b[3:0]; i4.cin = c[0]; i4.sub = s[0];
                                i4.start = 1'b1;
                                q4.push_back(model(4, s[0], 64'(a), 64'(b), c[0]));
                                @(posedge clk); #1;
                                i4.start = 1'b0; i4.a = 4'($urandom); i4.b = 4'($urandom);
                                repeat (5) @(posedge clk); #1;
                            end
            end
            begin : w2
                for (int n = 0; n < 1000; n++) begin
                    logic [1:0] ra, rb;
                    logic rc, rs;
                    ra = 2'($urandom); rb = 2'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                    i2.a = ra; i2.b = rb; i2.cin = rc; i2.sub = rs; i2.start = 1'b1;
                    q2.push_back(model(2, rs, {62'd0, ra}, {62'd0, rb}, rc));
                    @(posedge clk); #1;
                    i2.start = 1'b0; i2.a = 2'($urandom);
                    repeat (3) @(posedge clk); #1;
                end
            end
            begin : w32
                for (int n = 0; n < 1000; n++) begin
                    logic [31:0] ra, rb;
                    logic rc, rs;
                    ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
                    if (n < 4) begin
                        ra = (n[0]) ? 32'h7FFF_FFFF : 32'h8000_0000;
                        rb = (n[1]) ? 32'hFFFF_FFFF : 32'h0000_0001;
                    end
                    i32.a = ra; i32.b = rb; i32.cin = rc; i32.sub = rs; i32.start = 1'b1;
                    q32.push_back(model(32, rs, {32'd0, ra}, {32'd0, rb}, rc));
                    @(posedge clk); #1;
                    i32.start = 1'b0; i32.b = $urandom;
                    repeat (33) @(posedge clk); #1;
                end
            end
        join

        repeat (5) @(posedge clk); #1;
        chk("drain8",  66'(q8.size()),  66'd0);
        chk("drain4",  66'(q4.size()),  66'd0);
        chk("drain2",  66'(q2.size()),  66'd0);
        chk("drain32", 66'(q32.size()), 66'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. One full-adder cell plus a carry flop processes two WIDTH-bit operands LSB first, one bit per clock. A start/busy/done handshake lets a sequencer or testbench controller launch an operation and collect the registered sum, carry-out and signed-overflow flags. It generalises the combinational 1-bit full adder to arbitrary width, adds a subtract mode, and trades latency for area.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  launch request; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepted start edge.
- b  in  WIDTH  operand B; sampled on the accepted start edge.
- cin  in  1  carry-in; acts as borrow-in when sub=1; sampled with the operands.
- sub  in  1  0 = add, 1 = subtract (A − B); sampled with the operands.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is published.
- sum  out  WIDTH  registered result.
- cout  out  1  carry-out of the MSB. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1. On that edge:
  - op_a ← a.
  - op_b ← b XOR {WIDTH{sub}}.
  - carry ← cin XOR sub.
  - bit counter ← 0.
- RUN, each edge:
  - s = op_a[0] ^ op_b[0] ^ carry.
  - c = (op_a[0]&op_b[0]) | (op_b[0]&carry) | (carry&op_a[0]).
  - op_a and op_b shift right by 1.
  - s shifts into the MSB of the internal result shift register.
  - carry ← c; counter increments.
  - The last bit is processed when counter = WIDTH−1. Then:
    - sum ← completed shift register.
    - cout ← c.
    - ovf ← c XOR (carry into the MSB stage, i.e. the carry flop value during the last bit).
    - Next state DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- sum, cout and ovf change only on entry to DONE. They hold their value until the next result or a reset; partial results are never visible.
- start is ignored in RUN and DONE; no queuing. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: sum = (A + B + cin) mod 2^WIDTH when sub=0, and (A − B − cin) mod 2^WIDTH when sub=1.
- Counter width is clog2(WIDTH); no wrap occurs before the RUN exit.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter cleared.
- Reset takes priority over start and over every state transition.
- Reset asserted mid-RUN aborts the operation; no done pulse for the aborted operation.
- Start accepted at edge k:
  - busy=1 from edge k to edge k+WIDTH.
  - sum, cout, ovf and done=1 update at edge k+WIDTH.
  - done=0 at edge k+WIDTH+1.
  - Latency from start to result: WIDTH cycles.
- Earliest next accepted start is at edge k+WIDTH+2 (start must be high while in IDLE).
- Operand and mode inputs may change freely after the accepting edge without affecting the operation in flight.

## Test plan
- WIDTH=8, add: a=0x5A, b=0x3C, cin=0 -> done at start+8, sum=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
- WIDTH=8, add: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, subtract: a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1. Then a=0x05, b=0x05, cin=1 -> sum=0xFF, cout=0.
- Handshake: start held high continuously with changing operands -> ops accepted only every WIDTH+2 cycles; results match the operands present on each accepting edge; start pulses during RUN/DONE are ignored.
- Reset: rst_n low 4 cycles into an operation -> next edge busy=0, done=0, sum=0, cout=0, ovf=0, no done pulse. A following start gives a correct result.
- WIDTH=4: exhaustive 2×16×16×2 sweep of (sub, a, b, cin) against a behavioural +/− model, including signed-overflow check -> zero mismatches; WIDTH=2 and WIDTH=32 random 1000-op smoke runs also pass.
